// File: rtl/sram_axi_bridge.sv
// Bridges the CPU's sram-like fetch and data ports onto single-beat AXI reads/writes.
// One AXI transaction is outstanding at a time. Data accesses win over fetches.
module sram_axi_bridge #(
    parameter logic INST_ID = 1'b0,
    parameter logic DATA_ID = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_en,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    input  logic        data_en,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    input  logic        pipe_hold,
    output logic        ext_stall,
    output logic        arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic        rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {IDLE, D_AR, D_R, D_W, D_B, I_AR, I_R} state_t;

    state_t      state_q, state_d;
    logic        inst_ok_q, inst_ok_d;
    logic        data_ok_q, data_ok_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    // kseg0/kseg1 fold onto the low 512 MB; everything else is identity mapped.
    function automatic logic [31:0] map_addr(input logic [31:0] va);
        logic [31:0] pa;
        pa = va;
        if (va[31:29] == 3'b100 || va[31:29] == 3'b101) begin
            pa = {3'b000, va[28:0]};
        end
        return pa;
    endfunction

    function automatic logic [2:0] size_of(input logic [3:0] wen);
        logic [2:0] sz;
        case (wen)
            4'b0011, 4'b1100:                   sz = 3'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 3'd0;
            default:                            sz = 3'd2;
        endcase
        return sz;
    endfunction

    assign ext_stall  = (inst_en & ~inst_ok_q) | (data_en & ~data_ok_q);
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

    always_comb begin
        state_d      = state_q;
        inst_ok_d    = inst_ok_q;
        data_ok_d    = data_ok_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        arid         = INST_ID;
        araddr       = addr_q;
        arsize       = 3'd2;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awaddr       = addr_q;
        awsize       = size_of(wstrb_q);
        awvalid      = 1'b0;
        wdata        = wdata_q;
        wstrb        = wstrb_q;
        wvalid       = 1'b0;
        bready       = 1'b0;

        // The pipeline advanced this cycle, so the completed requests are consumed.
        if (!ext_stall && !pipe_hold) begin
            inst_ok_d = 1'b0;
            data_ok_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (data_en && !data_ok_q) begin
                    addr_d    = map_addr(data_addr);
                    wdata_d   = data_wdata;
                    wstrb_d   = data_wen;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = (data_wen != 4'b0000) ? D_W : D_AR;
                end else if (inst_en && !inst_ok_q) begin
                    addr_d  = map_addr(inst_addr);
                    state_d = I_AR;
                end
            end
            D_AR: begin
                arvalid = 1'b1;
                arid    = DATA_ID;
                if (arready) state_d = D_R;
            end
            I_AR: begin
                arvalid = 1'b1;
                arid    = INST_ID;
                if (arready) state_d = I_R;
            end
            D_R: begin
                rready = 1'b1;
                if (rvalid && rid == DATA_ID) begin
                    // A request withdrawn mid-flight drops its result.
                    if (data_en) begin
                        data_rdata_d = rdata;
                        data_ok_d    = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            I_R: begin
                rready = 1'b1;
                if (rvalid && rid == INST_ID) begin
                    if (inst_en) begin
                        inst_rdata_d = rdata;
                        inst_ok_d    = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            D_W: begin
                awvalid   = ~aw_done_q;
                wvalid    = ~w_done_q;
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) state_d = D_B;
            end
            D_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    if (data_en) data_ok_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_ok_q    <= inst_ok_d;
            data_ok_q    <= data_ok_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

endmodule
